// File: rtl/lcd_box_overlay_ctrl_pkg.sv
// Shared types and default constants for the LCD box overlay controller.
package lcd_box_overlay_ctrl_pkg;

    localparam logic [10:0] H_DISP_DEF    = 11'd640;
    localparam logic [10:0] V_DISP_DEF    = 11'd480;
    localparam logic [11:0] PLATE_RGB_DEF = 12'hFFF;
    localparam logic [11:0] CHAR_RGB_DEF  = 12'hF00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOAD    = 2'd2
    } state_e;

    typedef struct packed {
        logic       en;
        logic [9:0] left;
        logic [9:0] right;
        logic [9:0] up;
        logic [9:0] down;
    } box_t;

endpackage

// File: rtl/lcd_box_hit.sv
// Combinational border test of one box slot against the current pixel.
module lcd_box_hit
    import lcd_box_overlay_ctrl_pkg::*;
#(
    parameter logic [10:0] H_LCD_DISP = H_DISP_DEF,
    parameter logic [10:0] V_LCD_DISP = V_DISP_DEF
) (
    input  box_t       box_i,
    input  logic [9:0] px_i,
    input  logic [9:0] py_i,
    output logic       hit_o,
    output logic       valid_o
);

    logic in_disp;
    logic on_col;
    logic on_row;

    assign in_disp = ({1'b0, px_i} < H_LCD_DISP) && ({1'b0, py_i} < V_LCD_DISP);
    assign valid_o = box_i.en && (box_i.left < box_i.right) && (box_i.up < box_i.down);

    // Vertical edges span the full row range and horizontal edges the full column range,
    // so corners are covered by both terms.
    assign on_col = ((px_i == box_i.left) || (px_i == box_i.right)) &&
                    (py_i >= box_i.up) && (py_i <= box_i.down);
    assign on_row = ((py_i == box_i.up) || (py_i == box_i.down)) &&
                    (px_i >= box_i.left) && (px_i <= box_i.right);

    assign hit_o = valid_o && in_disp && (on_col || on_row);

endmodule

// File: rtl/lcd_box_overlay_ctrl.sv
// Multi-box border overlay: shadow/active box banks swapped in vertical blanking,
// per-pixel priority hit and registered RGB444 output.
module lcd_box_overlay_ctrl
    import lcd_box_overlay_ctrl_pkg::*;
#(
    parameter int          NUM_BOX    = 8,
    parameter logic [10:0] H_LCD_DISP = H_DISP_DEF,
    parameter logic [10:0] V_LCD_DISP = V_DISP_DEF,
    parameter logic [11:0] PLATE_RGB  = PLATE_RGB_DEF,
    parameter logic [11:0] CHAR_RGB   = CHAR_RGB_DEF,
    localparam int         IDX_W      = $clog2(NUM_BOX)
) (
    input  logic               lcd_clk,
    input  logic               sys_rst_n,
    input  logic [9:0]         pixel_xpos,
    input  logic [9:0]         pixel_ypos,
    input  logic               box_wr_valid,
    output logic               box_wr_ready,
    input  logic [IDX_W-1:0]   box_wr_idx,
    input  logic               box_wr_en,
    input  logic [9:0]         box_left,
    input  logic [9:0]         box_right,
    input  logic [9:0]         box_up,
    input  logic [9:0]         box_down,
    input  logic               box_commit,
    output logic               commit_ack,
    output logic [NUM_BOX-1:0] active_mask,
    output logic               border_flag,
    output logic [IDX_W-1:0]   border_idx,
    output logic [3:0]         VGA_R,
    output logic [3:0]         VGA_G,
    output logic [3:0]         VGA_B
);

    box_t             shadow_q [NUM_BOX];
    box_t             active_q [NUM_BOX];
    state_e           state_q;
    logic             commit_ack_q;
    logic             border_flag_q;
    logic [IDX_W-1:0] border_idx_q;
    logic [11:0]      rgb_q;

    logic               wr_fire;
    logic               idx_in_range;
    logic               blank_start;
    logic [NUM_BOX-1:0] hit;
    logic [NUM_BOX-1:0] slot_valid;
    logic               any_hit;
    logic [IDX_W-1:0]   win_idx_d;
    logic [11:0]        rgb_d;

    assign box_wr_ready = (state_q != ST_LOAD);
    assign wr_fire      = box_wr_valid && box_wr_ready;
    // Widened so a non power-of-two slot count still rejects the unused indices.
    assign idx_in_range = ({1'b0, box_wr_idx} < (IDX_W + 1)'(NUM_BOX));
    assign blank_start  = ({1'b0, pixel_ypos} == V_LCD_DISP) && (pixel_xpos == 10'd0);

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < NUM_BOX; k++) shadow_q[k] <= '0;
        end else if (wr_fire && idx_in_range) begin
            shadow_q[box_wr_idx] <= '{en: box_wr_en, left: box_left, right: box_right,
                                      up: box_up, down: box_down};
        end
    end

    // Writes stay open while a commit is pending: the copy happens in LOAD,
    // so anything written before then is part of the published set.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            commit_ack_q <= 1'b0;
            for (int k = 0; k < NUM_BOX; k++) active_q[k] <= '0;
        end else begin
            commit_ack_q <= (state_q == ST_LOAD);
            case (state_q)
                ST_IDLE: begin
                    if (box_commit) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (blank_start) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    active_q <= shadow_q;
                    state_q  <= box_commit ? ST_PENDING : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_BOX; k++) begin : g_hit
        lcd_box_hit #(
            .H_LCD_DISP (H_LCD_DISP),
            .V_LCD_DISP (V_LCD_DISP)
        ) u_hit (
            .box_i   (active_q[k]),
            .px_i    (pixel_xpos),
            .py_i    (pixel_ypos),
            .hit_o   (hit[k]),
            .valid_o (slot_valid[k])
        );
    end

    assign active_mask = slot_valid;
    assign any_hit     = |hit;

    always_comb begin
        win_idx_d = '0;
        for (int k = NUM_BOX - 1; k >= 0; k--) begin
            if (hit[k]) win_idx_d = IDX_W'(k);
        end
        rgb_d = 12'h000;
        if (any_hit) rgb_d = (win_idx_d == '0) ? PLATE_RGB : CHAR_RGB;
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            border_flag_q <= 1'b0;
            border_idx_q  <= '0;
            rgb_q         <= 12'h000;
        end else begin
            border_flag_q <= any_hit;
            border_idx_q  <= win_idx_d;
            rgb_q         <= rgb_d;
        end
    end

    assign commit_ack  = commit_ack_q;
    assign border_flag = border_flag_q;
    assign border_idx  = border_idx_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];

endmodule

// File: tb/tb_lcd_box_overlay_ctrl.sv
// Directed bench for lcd_box_overlay_ctrl: bank commit timing, priority and border geometry.
module tb_lcd_box_overlay_ctrl;

    logic       lcd_clk = 1'b0;
    logic       sys_rst_n;
    logic [9:0] pixel_xpos, pixel_ypos;
    logic       box_wr_valid, box_wr_ready, box_wr_en, box_commit, commit_ack;
    logic [2:0] box_wr_idx;
    logic [9:0] box_left, box_right, box_up, box_down;
    logic [7:0] active_mask;
    logic       border_flag;
    logic [2:0] border_idx;
    logic [3:0] VGA_R, VGA_G, VGA_B;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_box_overlay_ctrl dut (
        .lcd_clk      (lcd_clk),
        .sys_rst_n    (sys_rst_n),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .box_wr_valid (box_wr_valid),
        .box_wr_ready (box_wr_ready),
        .box_wr_idx   (box_wr_idx),
        .box_wr_en    (box_wr_en),
        .box_left     (box_left),
        .box_right    (box_right),
        .box_up       (box_up),
        .box_down     (box_down),
        .box_commit   (box_commit),
        .commit_ack   (commit_ack),
        .active_mask  (active_mask),
        .border_flag  (border_flag),
        .border_idx   (border_idx),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B)
    );

    always #5 lcd_clk = ~lcd_clk;

    task automatic tick();
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        pixel_xpos = 10'(x);
        pixel_ypos = 10'(y);
        tick();
    endtask

    task automatic chk_pix(input string tag, input int x, input int y,
                           input logic flag, input logic [2:0] idx, input logic [11:0] rgb);
        pix(x, y);
        check({tag, "_flag"}, 32'(border_flag), 32'(flag));
        check({tag, "_idx"}, 32'(border_idx), 32'(idx));
        check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'(rgb));
    endtask

    task automatic write_box(input int idx, input logic en, input int l, input int r,
                             input int u, input int d);
        bit acc;
        acc          = 1'b0;
        box_wr_valid = 1'b1;
        box_wr_idx   = 3'(idx);
        box_wr_en    = en;
        box_left     = 10'(l);
        box_right    = 10'(r);
        box_up       = 10'(u);
        box_down     = 10'(d);
        for (int i = 0; i < 8 && !acc; i++) begin
            if (box_wr_ready) acc = 1'b1;
            tick();
        end
        box_wr_valid = 1'b0;
        check("write_accept", 32'(acc), 32'd1);
    endtask

    task automatic commit();
        box_commit = 1'b1;
        tick();
        box_commit = 1'b0;
    endtask

    task automatic blank(input string tag, input logic exp_ack);
        pixel_xpos = 10'd0;
        pixel_ypos = 10'd480;
        tick();
        check({tag, "_ready"}, 32'(box_wr_ready), 32'(!exp_ack));
        pixel_xpos = 10'd1;
        tick();
        check({tag, "_ack"}, 32'(commit_ack), 32'(exp_ack));
        pixel_xpos = 10'd2;
        tick();
        check({tag, "_ack_off"}, 32'(commit_ack), 32'd0);
    endtask

    initial begin
        int flags;
        sys_rst_n    = 1'b0;
        pixel_xpos   = '0;
        pixel_ypos   = '0;
        box_wr_valid = 1'b0;
        box_wr_idx   = '0;
        box_wr_en    = 1'b0;
        box_left     = '0;
        box_right    = '0;
        box_up       = '0;
        box_down     = '0;
        box_commit   = 1'b0;
        tick();
        tick();
        check("rst_flag", 32'(border_flag), 32'd0);
        check("rst_idx", 32'(border_idx), 32'd0);
        check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        check("rst_mask", 32'(active_mask), 32'd0);
        check("rst_ack", 32'(commit_ack), 32'd0);
        check("rst_ready", 32'(box_wr_ready), 32'd1);
        sys_rst_n = 1'b1;
        tick();

        // Empty active bank: sparse frame scan plus a blanking with nothing pending
        flags = 0;
        for (int y = 0; y < 480; y += 16)
            for (int x = 0; x < 640; x += 16) begin
                pix(x, y);
                if (border_flag) flags++;
            end
        check("scan_empty_flags", 32'(flags), 32'd0);
        check("scan_empty_mask", 32'(active_mask), 32'd0);
        blank("blank_nocommit", 1'b0);

        // Single plate box
        write_box(0, 1'b1, 100, 300, 200, 260);
        commit();
        chk_pix("pre_load", 100, 230, 1'b0, 3'd0, 12'h000);
        blank("blank_plate", 1'b1);
        check("mask_plate", 32'(active_mask), 32'h01);
        chk_pix("plate_left", 100, 230, 1'b1, 3'd0, 12'hFFF);
        chk_pix("plate_corner", 300, 200, 1'b1, 3'd0, 12'hFFF);
        chk_pix("plate_inside", 150, 230, 1'b0, 3'd0, 12'h000);
        chk_pix("plate_bottom", 150, 260, 1'b1, 3'd0, 12'hFFF);
        chk_pix("plate_right_out", 301, 230, 1'b0, 3'd0, 12'h000);
        chk_pix("plate_below", 100, 261, 1'b0, 3'd0, 12'h000);

        // Overlap priority, then clear the plate
        write_box(3, 1'b1, 120, 400, 200, 300);
        commit();
        blank("blank_overlap", 1'b1);
        check("mask_overlap", 32'(active_mask), 32'h09);
        chk_pix("overlap_win0", 120, 200, 1'b1, 3'd0, 12'hFFF);
        write_box(0, 1'b0, 0, 0, 0, 0);
        commit();
        blank("blank_clear0", 1'b1);
        check("mask_clear0", 32'(active_mask), 32'h08);
        chk_pix("overlap_win3", 120, 200, 1'b1, 3'd3, 12'hF00);
        chk_pix("slot3_corner", 400, 300, 1'b1, 3'd3, 12'hF00);
        chk_pix("cleared_plate", 100, 230, 1'b0, 3'd0, 12'h000);

        // Uncommitted write stays invisible, then commit coinciding with LOAD
        write_box(2, 1'b1, 10, 50, 10, 50);
        chk_pix("uncommitted", 10, 20, 1'b0, 3'd0, 12'h000);
        blank("blank_uncommitted", 1'b0);
        chk_pix("uncommitted_next", 10, 20, 1'b0, 3'd0, 12'h000);
        check("mask_uncommitted", 32'(active_mask), 32'h08);
        commit();
        pixel_xpos = 10'd0;
        pixel_ypos = 10'd480;
        tick();
        check("load_ready_low", 32'(box_wr_ready), 32'd0);
        box_commit = 1'b1;
        pixel_xpos = 10'd1;
        tick();
        box_commit = 1'b0;
        check("load_commit_ack1", 32'(commit_ack), 32'd1);
        check("mask_slot2", 32'(active_mask), 32'h0C);
        chk_pix("slot2_left", 10, 20, 1'b1, 3'd2, 12'hF00);
        blank("blank_second_ack", 1'b1);

        // Write during LOAD is held, then degenerate and off-display boxes
        commit();
        pixel_xpos = 10'd0;
        pixel_ypos = 10'd480;
        tick();
        box_wr_valid = 1'b1;
        box_wr_idx   = 3'd4;
        box_wr_en    = 1'b1;
        box_left     = 10'd500;
        box_right    = 10'd600;
        box_up       = 10'd400;
        box_down     = 10'd450;
        pixel_xpos   = 10'd1;
        check("held_ready_low", 32'(box_wr_ready), 32'd0);
        tick();
        check("held_ready_back", 32'(box_wr_ready), 32'd1);
        check("held_ack", 32'(commit_ack), 32'd1);
        tick();
        box_wr_valid = 1'b0;
        check("held_not_active", 32'(active_mask), 32'h0C);
        write_box(1, 1'b1, 50, 50, 10, 100);
        write_box(5, 1'b1, 600, 700, 100, 250);
        commit();
        blank("blank_held", 1'b1);
        check("mask_held", 32'(active_mask), 32'h3C);
        chk_pix("degenerate", 50, 80, 1'b0, 3'd0, 12'h000);
        chk_pix("held_slot4", 500, 420, 1'b1, 3'd4, 12'hF00);
        chk_pix("off_display", 700, 150, 1'b0, 3'd0, 12'h000);
        chk_pix("slot5_left", 600, 150, 1'b1, 3'd5, 12'hF00);

        // Reset mid-frame while a commit is pending
        write_box(0, 1'b1, 100, 300, 200, 260);
        commit();
        chk_pix("pre_reset", 600, 240, 1'b1, 3'd5, 12'hF00);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_flag", 32'(border_flag), 32'd0);
        check("mid_rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        check("mid_rst_mask", 32'(active_mask), 32'd0);
        check("mid_rst_ready", 32'(box_wr_ready), 32'd1);
        tick();
        sys_rst_n = 1'b1;
        tick();
        blank("blank_after_rst", 1'b0);
        chk_pix("after_rst_nohit", 600, 240, 1'b0, 3'd0, 12'h000);
        write_box(0, 1'b1, 100, 300, 200, 260);
        commit();
        blank("blank_fresh", 1'b1);
        check("mask_fresh", 32'(active_mask), 32'h01);
        chk_pix("fresh_plate", 100, 230, 1'b1, 3'd0, 12'hFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
